// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX->MEM pipeline register with valid/ready handshake, flush and forwarding tap
// Optional two-entry skid buffer with registered in_ready: define EX_MEM_SKID_EN.
module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mem_write,
    input  logic               in_mem_read,
    input  logic               in_mem_to_reg,
    input  logic               in_reg_write,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [DATA_W-1:0]  in_write_data,
    input  logic [RADDR_W-1:0] in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mem_write,
    output logic               out_mem_read,
    output logic               out_mem_to_reg,
    output logic               out_reg_write,
    output logic [DATA_W-1:0]  out_alu_result,
    output logic [DATA_W-1:0]  out_write_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               fwd_en,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]  fwd_data
);
    localparam int ENTRY_W = 4 + 2 * DATA_W + RADDR_W;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} stateT;

    stateT              state, stateNext;
    logic [ENTRY_W-1:0] mainEntry, skidEntry, inEntry;
    logic               xferIn, xferOut;
    logic               loadMain, loadSkid, skidToMain;
    logic               inRegWrite;
    logic               mainMemWrite, mainMemRead, mainMemToReg, mainRegWrite;

    // Writes to x0 are dropped here so MEM/WB and the forwarding tap never see them.
    assign inRegWrite = in_reg_write && (in_rd != '0);
    assign inEntry    = {in_mem_write, in_mem_read, in_mem_to_reg, inRegWrite,
                         in_alu_result, in_write_data, in_rd};

    assign out_valid = (state != EMPTY);
    assign xferIn    = in_valid && in_ready;
    assign xferOut   = out_valid && out_ready;

`ifdef EX_MEM_SKID_EN
    logic inReadyQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inReadyQ <= 1'b1;
        end else begin
            inReadyQ <= (stateNext != TWO);
        end
    end

    assign in_ready = inReadyQ;
`else
    assign in_ready = (state == EMPTY) || out_ready;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        loadMain   = 1'b0;
        loadSkid   = 1'b0;
        skidToMain = 1'b0;
        case (state)
            EMPTY: begin
                if (xferIn) begin
                    stateNext = ONE;
                    loadMain  = 1'b1;
                end
            end
            ONE: begin
                if (xferIn && xferOut) begin
                    loadMain = 1'b1;
                end else if (xferIn) begin
                    stateNext = TWO;
                    loadSkid  = 1'b1;
                end else if (xferOut) begin
                    stateNext = EMPTY;
                end
            end
            TWO: begin
                if (xferOut) begin
                    stateNext  = ONE;
                    skidToMain = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
        // Flush wins over any capture: data registers keep their old contents.
        if (flush) begin
            stateNext  = EMPTY;
            loadMain   = 1'b0;
            loadSkid   = 1'b0;
            skidToMain = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mainEntry <= '0;
            skidEntry <= '0;
        end else begin
            if (skidToMain) begin
                mainEntry <= skidEntry;
            end else if (loadMain) begin
                mainEntry <= inEntry;
            end
            if (loadSkid) begin
                skidEntry <= inEntry;
            end
        end
    end

    assign {mainMemWrite, mainMemRead, mainMemToReg, mainRegWrite,
            out_alu_result, out_write_data, out_rd} = mainEntry;

    assign out_mem_write  = out_valid && mainMemWrite;
    assign out_mem_read   = out_valid && mainMemRead;
    assign out_mem_to_reg = out_valid && mainMemToReg;
    assign out_reg_write  = out_valid && mainRegWrite;

    // Loads are excluded: their value only exists after the memory access.
    assign fwd_en   = out_reg_write && !out_mem_to_reg;
    assign fwd_rd   = out_rd;
    assign fwd_data = out_alu_result;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - randomized self-checking bench for ex_mem_pipe against a queue model
// Honors EX_MEM_SKID_EN the same way as the design.
module tb_ex_mem_pipe;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic          in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
    logic          out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write;
    logic [DW-1:0] in_alu_result, in_write_data, out_alu_result, out_write_data, fwd_data;
    logic [RW-1:0] in_rd, out_rd, fwd_rd;
    logic          fwd_en;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_W(DW), .RADDR_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_alu_result(in_alu_result), .in_write_data(in_write_data), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_alu_result(out_alu_result), .out_write_data(out_write_data), .out_rd(out_rd),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    typedef struct packed {
        logic          mw;
        logic          mr;
        logic          m2r;
        logic          rw;
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [RW-1:0] rd;
    } entT;

    entT q[$];
    entT pend[$];
    entT last;
    int  checks = 0;
    int  errors = 0;
    bit  checkEn = 1'b0;
    bit  lastXin;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic expReady();
`ifdef EX_MEM_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    // Model: a FIFO of the accepted entries; head is what MEM sees, last head persists.
    task automatic step();
        entT  cap;
        logic rdy, xout;
        rdy     = expReady();
        xout    = (q.size() > 0) && out_ready;
        lastXin = 1'b0;
        if (!rst_n) begin
            q.delete();
            last = '0;
        end else begin
            lastXin = in_valid && rdy;
            cap.mw  = in_mem_write;
            cap.mr  = in_mem_read;
            cap.m2r = in_mem_to_reg;
            cap.rw  = in_reg_write && (in_rd != 0);
            cap.alu = in_alu_result;
            cap.wd  = in_write_data;
            cap.rd  = in_rd;
            if (flush) begin
                q.delete();
            end else begin
                if (xout) void'(q.pop_front());
                if (lastXin) q.push_back(cap);
                if (q.size() > 0) last = q[0];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step();
        #1;
    endtask

    task automatic driveTick(input logic ordy);
        out_ready = ordy;
        if (pend.size() > 0) begin
            in_valid      = 1'b1;
            in_mem_write  = pend[0].mw;
            in_mem_read   = pend[0].mr;
            in_mem_to_reg = pend[0].m2r;
            in_reg_write  = pend[0].rw;
            in_alu_result = pend[0].alu;
            in_write_data = pend[0].wd;
            in_rd         = pend[0].rd;
        end else begin
            in_valid = 1'b0;
        end
        tick();
        if (lastXin && pend.size() > 0) void'(pend.pop_front());
    endtask

    function automatic entT mkEnt(input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                                  input logic rw, input logic mr, input logic m2r, input logic mw);
        entT e;
        e.mw = mw; e.mr = mr; e.m2r = m2r; e.rw = rw;
        e.alu = alu; e.wd = ~alu; e.rd = rd;
        return e;
    endfunction

    function automatic entT randEnt();
        entT e;
        e.mw  = 1'($urandom);
        e.mr  = 1'($urandom);
        e.m2r = 1'($urandom);
        e.rw  = 1'($urandom);
        e.alu = $urandom;
        e.wd  = $urandom;
        e.rd  = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
        return e;
    endfunction

    always @(negedge clk) begin
        entT  e;
        logic v;
        if (checkEn) begin
            e = last;
            v = (q.size() > 0);
            chk("in_ready", in_ready, expReady());
            chk("out_valid", out_valid, v);
            chk("out_mem_write", out_mem_write, v && e.mw);
            chk("out_mem_read", out_mem_read, v && e.mr);
            chk("out_mem_to_reg", out_mem_to_reg, v && e.m2r);
            chk("out_reg_write", out_reg_write, v && e.rw);
            chk("out_alu_result", out_alu_result, e.alu);
            chk("out_write_data", out_write_data, e.wd);
            chk("out_rd", out_rd, e.rd);
            chk("fwd_en", fwd_en, v && e.rw && !e.m2r);
            chk("fwd_rd", fwd_rd, e.rd);
            chk("fwd_data", fwd_data, e.alu);
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mem_write = 1'b0; in_mem_read = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
        in_alu_result = '0; in_write_data = '0; in_rd = '0;

        tick();
        checkEn = 1'b1;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu", out_alu_result, 0);
        chk("rst_fwd_en", fwd_en, 0);
        rst_n = 1'b1;

        pend.push_back(mkEnt(32'h0000_1234, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        driveTick(1'b1);
        chk("single_valid", out_valid, 1);
        chk("single_alu", out_alu_result, 64'h1234);
        chk("single_rd", out_rd, 7);
        chk("single_fwd_en", fwd_en, 1);
        chk("single_fwd_rd", fwd_rd, 7);
        driveTick(1'b1);

        pend.push_back(mkEnt(32'hA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        pend.push_back(mkEnt(32'hB, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        pend.push_back(mkEnt(32'hC, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) driveTick(1'b0);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head_a", out_alu_result, 64'hA);
        driveTick(1'b1);
        chk("bp_head_b", out_alu_result, 64'hB);
        driveTick(1'b1);
        chk("bp_head_c", out_alu_result, 64'hC);
        for (int i = 0; i < 4; i++) driveTick(1'b1);

        pend.push_back(mkEnt(32'hABCD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        driveTick(1'b1);
        chk("x0_valid", out_valid, 1);
        chk("x0_reg_write", out_reg_write, 0);
        chk("x0_fwd_en", fwd_en, 0);
        chk("x0_alu", out_alu_result, 64'hABCD);

        pend.push_back(mkEnt(32'h100, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0));
        driveTick(1'b1);
        chk("load_fwd_en", fwd_en, 0);
        chk("load_mem_read", out_mem_read, 1);
        chk("load_reg_write", out_reg_write, 1);
        driveTick(1'b1);

        pend.push_back(mkEnt(32'hD, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1));
        pend.push_back(mkEnt(32'hE, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        driveTick(1'b0);
        driveTick(1'b0);
        pend.push_back(mkEnt(32'hF, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
        flush = 1'b1;
        driveTick(1'b0);
        flush = 1'b0;
        pend.delete();
        chk("flush_valid", out_valid, 0);
        chk("flush_mem_write", out_mem_write, 0);
        chk("flush_reg_write", out_reg_write, 0);
        driveTick(1'b1);
        chk("flush_stays_empty", out_valid, 0);

        pend.push_back(mkEnt(32'h11, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        pend.push_back(mkEnt(32'h22, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0));
        driveTick(1'b0);
        driveTick(1'b0);
        rst_n = 1'b0;
        driveTick(1'b0);
        rst_n = 1'b1;
        pend.delete();
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);

        for (int i = 0; i < 2000; i++) begin
            if (pend.size() == 0 && $urandom_range(0, 3) != 0) pend.push_back(randEnt());
            flush = ($urandom_range(0, 31) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            if ((i % 200) < 100) driveTick($urandom_range(0, 3) != 0);
            else driveTick($urandom_range(0, 2) == 0);
        end
        flush = 1'b0;
        rst_n = 1'b1;
        pend.delete();
        for (int i = 0; i < 5; i++) driveTick(1'b1);
        chk("final_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
